// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, applies static branch prediction
// and buffers fetched instructions in a FIFO queue for the decoder.
module instr_fetch #(
    parameter int          IQ_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] rollback_pc,
    output logic [31:0] if_ain,
    input  logic        if_instr_out_en,
    input  logic [31:0] if_instr_out,
    output logic        iq_out_valid,
    output logic [31:0] iq_out_instr,
    output logic [31:0] iq_out_pc,
    output logic        iq_out_pred_taken,
    input  logic        iq_out_ready
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(IQ_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0]      pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic [31:0] iq_instr [IQ_DEPTH];
    logic [31:0] iq_pc    [IQ_DEPTH];
    logic        iq_pred  [IQ_DEPTH];

    logic signed [31:0] imm_j;
    logic signed [31:0] imm_b;
    logic               pred;
    logic [31:0]        next_pc;
    logic               push;
    logic               pop;

    // Static prediction: JAL always taken, backward conditional branches taken.
    always_comb begin
        imm_j   = {{11{if_instr_out[31]}}, if_instr_out[31], if_instr_out[19:12],
                   if_instr_out[20], if_instr_out[30:21], 1'b0};
        imm_b   = {{19{if_instr_out[31]}}, if_instr_out[31], if_instr_out[7],
                   if_instr_out[30:25], if_instr_out[11:8], 1'b0};
        pred    = 1'b0;
        next_pc = pc + 32'd4;
        case (if_instr_out[6:0])
            OP_JAL: begin
                pred    = 1'b1;
                next_pc = pc + $unsigned(imm_j);
            end
            OP_BRANCH: begin
                pred = if_instr_out[31];
                if (if_instr_out[31]) next_pc = pc + $unsigned(imm_b);
            end
            default: ;
        endcase
    end

    // Full is judged before any same-cycle pop, so a full queue never pushes.
    assign push = if_instr_out_en && (count != FULL_CNT);
    assign pop  = iq_out_ready && (count != '0);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                pc    <= rollback_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                    pc   <= next_pc;
                end
                if (pop) head <= head + 1'b1;
                count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            end
        end
    end

    // Queue payload carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (rdy_in && !roll_back && push) begin
            iq_instr[tail] <= if_instr_out;
            iq_pc[tail]    <= pc;
            iq_pred[tail]  <= pred;
        end
    end

    assign if_ain            = pc;
    assign iq_out_valid      = (count != '0);
    assign iq_out_instr      = iq_out_valid ? iq_instr[head] : 32'h0;
    assign iq_out_pc         = iq_out_valid ? iq_pc[head]    : 32'h0;
    assign iq_out_pred_taken = iq_out_valid ? iq_pred[head]  : 1'b0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, prediction, rollback,
// full-queue push/pop, stall and asynchronous reset.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic [31:0] rollback_pc;
    logic [31:0] if_ain;
    logic        if_instr_out_en;
    logic [31:0] if_instr_out;
    logic        iq_out_valid;
    logic [31:0] iq_out_instr;
    logic [31:0] iq_out_pc;
    logic        iq_out_pred_taken;
    logic        iq_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.IQ_DEPTH(16), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .roll_back        (roll_back),
        .rollback_pc      (rollback_pc),
        .if_ain           (if_ain),
        .if_instr_out_en  (if_instr_out_en),
        .if_instr_out     (if_instr_out),
        .iq_out_valid     (iq_out_valid),
        .iq_out_instr     (iq_out_instr),
        .iq_out_pc        (iq_out_pc),
        .iq_out_pred_taken(iq_out_pred_taken),
        .iq_out_ready     (iq_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        roll_back       = 1'b1;
        rollback_pc     = target;
        if_instr_out_en = 1'b0;
        iq_out_ready    = 1'b0;
        step();
        roll_back = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; rollback_pc = 32'h0;
        if_instr_out_en = 1'b0; if_instr_out = 32'h0; iq_out_ready = 1'b0;
        #1;
        n_checks++;
        if (if_ain !== 32'h0) begin n_fail++; $display("FAIL reset_ain got %h want %h", if_ain, 32'h0); end
        n_checks++;
        if (iq_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", iq_out_valid); end
        n_checks++;
        if (iq_out_instr !== 32'h0 || iq_out_pc !== 32'h0 || iq_out_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_head got %h/%h/%b want 0/0/0", iq_out_instr, iq_out_pc, iq_out_pred_taken);
        end
        step();
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_sequential();
        if_instr_out_en = 1'b1; if_instr_out = NOP; iq_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (if_ain !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_ain[%0d] got %h want %h", i, if_ain, 32'(4 * i)); end
            step();
        end
        n_checks++;
        if (if_ain !== 32'h40) begin n_fail++; $display("FAIL seq_full_ain got %h want 40", if_ain); end
        n_checks++;
        if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'h0 || iq_out_instr !== NOP || iq_out_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL seq_head got %b/%h/%h/%b want 1/0/%h/0", iq_out_valid, iq_out_pc, iq_out_instr, iq_out_pred_taken, NOP);
        end
        step();
        n_checks++;
        if (if_ain !== 32'h40) begin n_fail++; $display("FAIL seq_hold_full got %h want 40", if_ain); end
    endtask

    task automatic test_push_pop_full();
        if_instr_out_en = 1'b1; iq_out_ready = 1'b1;
        step();
        n_checks++;
        if (if_ain !== 32'h40 || iq_out_pc !== 32'h4) begin
            n_fail++; $display("FAIL full_pushpop got ain %h head %h want 40/4", if_ain, iq_out_pc);
        end
        iq_out_ready = 1'b0;
        step();
        n_checks++;
        if (if_ain !== 32'h44) begin n_fail++; $display("FAIL full_refill got %h want 44", if_ain); end
        step();
        n_checks++;
        if (if_ain !== 32'h44) begin n_fail++; $display("FAIL full_again got %h want 44", if_ain); end
    endtask

    task automatic test_push_pop_mid();
        redirect(32'h500);
        if_instr_out_en = 1'b1; if_instr_out = NOP; iq_out_ready = 1'b0;
        repeat (8) step();
        iq_out_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (if_ain !== 32'h52C || iq_out_pc !== 32'h50C) begin
            n_fail++; $display("FAIL mid_pushpop got ain %h head %h want 52c/50c", if_ain, iq_out_pc);
        end
        iq_out_ready = 1'b0;
        repeat (9) step();
        n_checks++;
        if (if_ain !== 32'h54C) begin n_fail++; $display("FAIL mid_count8 got %h want 54c", if_ain); end
    endtask

    task automatic test_jal();
        redirect(32'h100);
        if_instr_out_en = 1'b1; if_instr_out = 32'h0100006F;
        step();
        if_instr_out_en = 1'b0;
        n_checks++;
        if (if_ain !== 32'h110) begin n_fail++; $display("FAIL jal_target got %h want 110", if_ain); end
        n_checks++;
        if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'h100 || iq_out_pred_taken !== 1'b1 || iq_out_instr !== 32'h0100006F) begin
            n_fail++; $display("FAIL jal_entry got %b/%h/%b/%h want 1/100/1/0100006f", iq_out_valid, iq_out_pc, iq_out_pred_taken, iq_out_instr);
        end
    endtask

    task automatic test_branch();
        redirect(32'h200);
        if_instr_out_en = 1'b1; if_instr_out = 32'hFE000CE3;
        step();
        if_instr_out_en = 1'b0;
        n_checks++;
        if (if_ain !== 32'h1F8 || iq_out_pred_taken !== 1'b1 || iq_out_pc !== 32'h200) begin
            n_fail++; $display("FAIL br_back got %h/%b/%h want 1f8/1/200", if_ain, iq_out_pred_taken, iq_out_pc);
        end
        iq_out_ready = 1'b1;
        step();
        iq_out_ready = 1'b0;
        n_checks++;
        if (iq_out_valid !== 1'b0 || iq_out_pc !== 32'h0) begin
            n_fail++; $display("FAIL br_pop got %b/%h want 0/0", iq_out_valid, iq_out_pc);
        end
        redirect(32'h200);
        if_instr_out_en = 1'b1; if_instr_out = 32'h00000463;
        step();
        n_checks++;
        if (if_ain !== 32'h204 || iq_out_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL br_fwd got %h/%b want 204/0", if_ain, iq_out_pred_taken);
        end
        if_instr_out = 32'hFFF00067;
        step();
        if_instr_out_en = 1'b0;
        n_checks++;
        if (if_ain !== 32'h208) begin n_fail++; $display("FAIL jalr_seq got %h want 208", if_ain); end
    endtask

    task automatic test_miss();
        if_instr_out_en = 1'b0;
        repeat (2) step();
        n_checks++;
        if (if_ain !== 32'h208) begin n_fail++; $display("FAIL miss_hold got %h want 208", if_ain); end
    endtask

    task automatic test_rollback_priority();
        redirect(32'h0);
        if_instr_out_en = 1'b1; if_instr_out = NOP;
        repeat (5) step();
        roll_back = 1'b1; rollback_pc = 32'h3000; iq_out_ready = 1'b1;
        step();
        roll_back = 1'b0; if_instr_out_en = 1'b0; iq_out_ready = 1'b0;
        n_checks++;
        if (iq_out_valid !== 1'b0 || if_ain !== 32'h3000 || iq_out_instr !== 32'h0) begin
            n_fail++; $display("FAIL rb_prio got %b/%h/%h want 0/3000/0", iq_out_valid, if_ain, iq_out_instr);
        end
    endtask

    task automatic test_stall_reset();
        if_instr_out_en = 1'b1; if_instr_out = NOP;
        repeat (2) step();
        rdy_in = 1'b0; roll_back = 1'b1; rollback_pc = 32'h7000; iq_out_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (if_ain !== 32'h3008 || iq_out_valid !== 1'b1 || iq_out_pc !== 32'h3000) begin
            n_fail++; $display("FAIL stall got %h/%b/%h want 3008/1/3000", if_ain, iq_out_valid, iq_out_pc);
        end
        rdy_in = 1'b1; roll_back = 1'b0; iq_out_ready = 1'b0; if_instr_out_en = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (if_ain !== 32'h0 || iq_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got %h/%b want 0/0", if_ain, iq_out_valid);
        end
        step();
        rst_in = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_push_pop_full();
        test_push_pop_mid();
        test_jal();
        test_branch();
        test_miss();
        test_rollback_priority();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
